// File: rtl/reservation_station.sv
// rtl/reservation_station.sv - ALU/branch reservation station with dual-broadcast operand capture
module reservation_station #(
    parameter int              RS_SIZE    = 16,
    parameter int              IDX_W      = 4,
    parameter int              OP_W       = 6,
    parameter int              ROB_W      = 4,
    parameter logic [OP_W-1:0] OPNUM_NULL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rdy,
    input  logic             flush,
    input  logic             valid_from_dsp,
    input  logic [OP_W-1:0]  opnum_from_dsp,
    input  logic [31:0]      V1_from_dsp,
    input  logic [31:0]      V2_from_dsp,
    input  logic             Q1_pend_from_dsp,
    input  logic             Q2_pend_from_dsp,
    input  logic [ROB_W-1:0] Q1_from_dsp,
    input  logic [ROB_W-1:0] Q2_from_dsp,
    input  logic [31:0]      imm_from_dsp,
    input  logic [31:0]      pc_from_dsp,
    input  logic [ROB_W-1:0] rob_id_from_dsp,
    input  logic             alu_valid,
    input  logic [ROB_W-1:0] alu_rob_id,
    input  logic [31:0]      alu_data,
    input  logic             lsb_valid,
    input  logic [ROB_W-1:0] lsb_rob_id,
    input  logic [31:0]      lsb_data,
    output logic             full,
    output logic [OP_W-1:0]  opnum_to_ex,
    output logic [31:0]      V1_to_ex,
    output logic [31:0]      V2_to_ex,
    output logic [31:0]      imm_to_ex,
    output logic [31:0]      pc_to_ex,
    output logic [ROB_W-1:0] rob_id_to_ex
);

    logic [RS_SIZE-1:0] busy_q, p1_q, p2_q;
    logic [OP_W-1:0]    op_q   [RS_SIZE];
    logic [31:0]        v1_q   [RS_SIZE];
    logic [31:0]        v2_q   [RS_SIZE];
    logic [31:0]        imm_q  [RS_SIZE];
    logic [31:0]        pc_q   [RS_SIZE];
    logic [ROB_W-1:0]   q1_q   [RS_SIZE];
    logic [ROB_W-1:0]   q2_q   [RS_SIZE];
    logic [ROB_W-1:0]   rob_q  [RS_SIZE];
    logic [IDX_W:0]     count_q, count_d;
    logic               full_q;

    logic [RS_SIZE-1:0] ready;
    logic [IDX_W-1:0]   issue_idx, alloc_idx;
    logic               issue_en, alloc_en, free_found;
    logic               d1_p, d2_p;
    logic [31:0]        d1_v, d2_v;

    assign full  = full_q;
    assign ready = busy_q & ~p1_q & ~p2_q;

    // Lowest index wins: scan downward so the last hit is the smallest.
    always_comb begin
        issue_en   = 1'b0;
        issue_idx  = '0;
        free_found = 1'b0;
        alloc_idx  = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (ready[i]) begin
                issue_en  = 1'b1;
                issue_idx = IDX_W'(i);
            end
            if (!busy_q[i]) begin
                free_found = 1'b1;
                alloc_idx  = IDX_W'(i);
            end
        end
        alloc_en = valid_from_dsp && !full_q && free_found;
        count_d  = count_q + (IDX_W+1)'(alloc_en) - (IDX_W+1)'(issue_en);
    end

    // Dispatch bypass: a same-cycle broadcast resolves the incoming operand.
    always_comb begin
        d1_p = Q1_pend_from_dsp;
        d1_v = V1_from_dsp;
        if (Q1_pend_from_dsp && alu_valid && alu_rob_id == Q1_from_dsp) begin
            d1_p = 1'b0;
            d1_v = alu_data;
        end else if (Q1_pend_from_dsp && lsb_valid && lsb_rob_id == Q1_from_dsp) begin
            d1_p = 1'b0;
            d1_v = lsb_data;
        end
        d2_p = Q2_pend_from_dsp;
        d2_v = V2_from_dsp;
        if (Q2_pend_from_dsp && alu_valid && alu_rob_id == Q2_from_dsp) begin
            d2_p = 1'b0;
            d2_v = alu_data;
        end else if (Q2_pend_from_dsp && lsb_valid && lsb_rob_id == Q2_from_dsp) begin
            d2_p = 1'b0;
            d2_v = lsb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q       <= '0;
            p1_q         <= '0;
            p2_q         <= '0;
            count_q      <= '0;
            full_q       <= 1'b0;
            opnum_to_ex  <= OPNUM_NULL;
            V1_to_ex     <= '0;
            V2_to_ex     <= '0;
            imm_to_ex    <= '0;
            pc_to_ex     <= '0;
            rob_id_to_ex <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                op_q[i]  <= '0;
                v1_q[i]  <= '0;
                v2_q[i]  <= '0;
                imm_q[i] <= '0;
                pc_q[i]  <= '0;
                q1_q[i]  <= '0;
                q2_q[i]  <= '0;
                rob_q[i] <= '0;
            end
        end else if (rdy) begin
            if (flush) begin
                busy_q      <= '0;
                count_q     <= '0;
                full_q      <= 1'b0;
                opnum_to_ex <= OPNUM_NULL;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (busy_q[i] && p1_q[i]) begin
                        if (alu_valid && alu_rob_id == q1_q[i]) begin
                            v1_q[i] <= alu_data;
                            p1_q[i] <= 1'b0;
                        end else if (lsb_valid && lsb_rob_id == q1_q[i]) begin
                            v1_q[i] <= lsb_data;
                            p1_q[i] <= 1'b0;
                        end
                    end
                    if (busy_q[i] && p2_q[i]) begin
                        if (alu_valid && alu_rob_id == q2_q[i]) begin
                            v2_q[i] <= alu_data;
                            p2_q[i] <= 1'b0;
                        end else if (lsb_valid && lsb_rob_id == q2_q[i]) begin
                            v2_q[i] <= lsb_data;
                            p2_q[i] <= 1'b0;
                        end
                    end
                end
                if (issue_en) begin
                    busy_q[issue_idx] <= 1'b0;
                    opnum_to_ex       <= op_q[issue_idx];
                    V1_to_ex          <= v1_q[issue_idx];
                    V2_to_ex          <= v2_q[issue_idx];
                    imm_to_ex         <= imm_q[issue_idx];
                    pc_to_ex          <= pc_q[issue_idx];
                    rob_id_to_ex      <= rob_q[issue_idx];
                end else begin
                    opnum_to_ex <= OPNUM_NULL;
                end
                // The allocated slot was idle before this edge, so it never collides with issue or wakeup.
                if (alloc_en) begin
                    busy_q[alloc_idx] <= 1'b1;
                    op_q[alloc_idx]   <= opnum_from_dsp;
                    v1_q[alloc_idx]   <= d1_v;
                    v2_q[alloc_idx]   <= d2_v;
                    p1_q[alloc_idx]   <= d1_p;
                    p2_q[alloc_idx]   <= d2_p;
                    q1_q[alloc_idx]   <= Q1_from_dsp;
                    q2_q[alloc_idx]   <= Q2_from_dsp;
                    imm_q[alloc_idx]  <= imm_from_dsp;
                    pc_q[alloc_idx]   <= pc_from_dsp;
                    rob_q[alloc_idx]  <= rob_id_from_dsp;
                end
                count_q <= count_d;
                full_q  <= (count_d == (IDX_W+1)'(RS_SIZE));
            end
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// tb/tb_reservation_station.sv - randomized + directed bench for reservation_station against a slot model
module tb_reservation_station;

    localparam int N = 16;
    localparam logic [5:0] NULL_OP = 6'd0;
    localparam logic [5:0] ADD = 6'd1, ADDI = 6'd2, SUB = 6'd3, XOR_OP = 6'd4, OR_OP = 6'd5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rdy = 1'b1, flush = 1'b0;
    logic        valid_from_dsp = 1'b0;
    logic [5:0]  opnum_from_dsp = '0;
    logic [31:0] V1_from_dsp = '0, V2_from_dsp = '0, imm_from_dsp = '0, pc_from_dsp = '0;
    logic        Q1_pend_from_dsp = 1'b0, Q2_pend_from_dsp = 1'b0;
    logic [3:0]  Q1_from_dsp = '0, Q2_from_dsp = '0, rob_id_from_dsp = '0;
    logic        alu_valid = 1'b0, lsb_valid = 1'b0;
    logic [3:0]  alu_rob_id = '0, lsb_rob_id = '0;
    logic [31:0] alu_data = '0, lsb_data = '0;
    logic        full;
    logic [5:0]  opnum_to_ex;
    logic [31:0] V1_to_ex, V2_to_ex, imm_to_ex, pc_to_ex;
    logic [3:0]  rob_id_to_ex;

    reservation_station dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush(flush),
        .valid_from_dsp(valid_from_dsp), .opnum_from_dsp(opnum_from_dsp),
        .V1_from_dsp(V1_from_dsp), .V2_from_dsp(V2_from_dsp),
        .Q1_pend_from_dsp(Q1_pend_from_dsp), .Q2_pend_from_dsp(Q2_pend_from_dsp),
        .Q1_from_dsp(Q1_from_dsp), .Q2_from_dsp(Q2_from_dsp),
        .imm_from_dsp(imm_from_dsp), .pc_from_dsp(pc_from_dsp), .rob_id_from_dsp(rob_id_from_dsp),
        .alu_valid(alu_valid), .alu_rob_id(alu_rob_id), .alu_data(alu_data),
        .lsb_valid(lsb_valid), .lsb_rob_id(lsb_rob_id), .lsb_data(lsb_data),
        .full(full), .opnum_to_ex(opnum_to_ex), .V1_to_ex(V1_to_ex), .V2_to_ex(V2_to_ex),
        .imm_to_ex(imm_to_ex), .pc_to_ex(pc_to_ex), .rob_id_to_ex(rob_id_to_ex)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          busy;
        logic [5:0]  op;
        logic [31:0] v1, v2, imm, pc;
        bit          p1, p2;
        logic [3:0]  q1, q2, rob;
    } slot_t;

    slot_t       m [N];
    logic [5:0]  e_op;
    logic [31:0] e_v1, e_v2, e_imm, e_pc;
    logic [3:0]  e_rob;
    bit          e_full;
    int          checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m[i] = '{default: '0};
        e_op = NULL_OP; e_v1 = '0; e_v2 = '0; e_imm = '0; e_pc = '0; e_rob = '0; e_full = 0;
    endtask

    // A pending operand takes the first broadcast naming its tag, ALU first.
    function automatic void resolve(inout bit p, inout logic [31:0] v, input logic [3:0] q);
        if (!p) return;
        if (alu_valid && alu_rob_id == q) begin v = alu_data; p = 0; end
        else if (lsb_valid && lsb_rob_id == q) begin v = lsb_data; p = 0; end
    endfunction

    task automatic model_step();
        int iss, fr, occ;
        slot_t nw;
        if (!rdy) return;
        if (flush) begin
            for (int i = 0; i < N; i++) m[i].busy = 0;
            e_op = NULL_OP; e_full = 0;
            return;
        end
        iss = -1; fr = -1;
        for (int i = 0; i < N; i++) begin
            if (iss < 0 && m[i].busy && !m[i].p1 && !m[i].p2) iss = i;
            if (fr < 0 && !m[i].busy) fr = i;
        end
        for (int i = 0; i < N; i++) if (m[i].busy) begin
            resolve(m[i].p1, m[i].v1, m[i].q1);
            resolve(m[i].p2, m[i].v2, m[i].q2);
        end
        if (iss >= 0) begin
            e_op = m[iss].op; e_v1 = m[iss].v1; e_v2 = m[iss].v2;
            e_imm = m[iss].imm; e_pc = m[iss].pc; e_rob = m[iss].rob;
            m[iss].busy = 0;
        end else e_op = NULL_OP;
        if (valid_from_dsp && !e_full && fr >= 0) begin
            nw = '{busy: 1, op: opnum_from_dsp, v1: V1_from_dsp, v2: V2_from_dsp,
                   imm: imm_from_dsp, pc: pc_from_dsp, p1: Q1_pend_from_dsp, p2: Q2_pend_from_dsp,
                   q1: Q1_from_dsp, q2: Q2_from_dsp, rob: rob_id_from_dsp};
            resolve(nw.p1, nw.v1, nw.q1);
            resolve(nw.p2, nw.v2, nw.q2);
            m[fr] = nw;
        end
        occ = 0;
        for (int i = 0; i < N; i++) occ += m[i].busy ? 1 : 0;
        e_full = (occ == N);
    endtask

    task automatic compare();
        chk("full", full, e_full);
        chk("opnum", opnum_to_ex, e_op);
        chk("V1", V1_to_ex, e_v1);
        chk("V2", V2_to_ex, e_v2);
        chk("imm", imm_to_ex, e_imm);
        chk("pc", pc_to_ex, e_pc);
        chk("rob_id", rob_id_to_ex, e_rob);
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic idle();
        valid_from_dsp = 0; alu_valid = 0; lsb_valid = 0; flush = 0; rdy = 1;
        Q1_pend_from_dsp = 0; Q2_pend_from_dsp = 0;
    endtask

    task automatic dsp(input logic [5:0] op, input logic [31:0] v1, input logic [31:0] v2,
                       input bit p1, input logic [3:0] q1, input bit p2, input logic [3:0] q2,
                       input logic [3:0] rob);
        valid_from_dsp = 1; opnum_from_dsp = op; V1_from_dsp = v1; V2_from_dsp = v2;
        Q1_pend_from_dsp = p1; Q1_from_dsp = q1; Q2_pend_from_dsp = p2; Q2_from_dsp = q2;
        rob_id_from_dsp = rob; imm_from_dsp = 32'h1000 + rob; pc_from_dsp = 32'h4000 + {rob, 2'b00};
    endtask

    initial begin
        model_reset();
        #12;
        chk("reset_full", full, 0);
        chk("reset_op", opnum_to_ex, NULL_OP);
        chk("reset_V1", V1_to_ex, 0);
        chk("reset_rob", rob_id_to_ex, 0);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;

        idle(); dsp(ADD, 5, 7, 0, 0, 0, 0, 3); step();
        idle(); step();
        chk("add_op", opnum_to_ex, ADD);
        chk("add_V1", V1_to_ex, 5);
        chk("add_V2", V2_to_ex, 7);
        chk("add_rob", rob_id_to_ex, 3);
        step();
        chk("add_null", opnum_to_ex, NULL_OP);

        idle(); dsp(ADDI, 0, 0, 1, 6, 0, 0, 4); step();
        idle(); step();
        lsb_valid = 1; lsb_rob_id = 6; lsb_data = 32'h100; step();
        idle(); step();
        chk("addi_op", opnum_to_ex, ADDI);
        chk("addi_V1", V1_to_ex, 32'h100);

        idle(); dsp(SUB, 1, 0, 0, 0, 1, 2, 5);
        alu_valid = 1; alu_rob_id = 2; alu_data = 9; step();
        idle(); step();
        chk("sub_op", opnum_to_ex, SUB);
        chk("sub_V2", V2_to_ex, 9);

        for (int i = 0; i < N; i++) begin
            idle(); dsp(ADD, 0, i, 1, 1, 0, 0, 4'(i)); step();
        end
        chk("fill_full", full, 1);
        idle(); dsp(OR_OP, 0, 0, 0, 0, 0, 0, 9); step();
        chk("full_ignored_op", opnum_to_ex, NULL_OP);
        idle(); alu_valid = 1; alu_rob_id = 1; alu_data = 32'h55; step();
        idle();
        for (int i = 0; i < N; i++) begin
            step();
            chk("order_rob", rob_id_to_ex, i);
            if (i == 0) chk("full_falls", full, 0);
        end
        step();
        chk("drained", opnum_to_ex, NULL_OP);

        for (int i = 0; i < 4; i++) begin
            idle(); dsp(SUB, 0, 0, 1, 7, 0, 0, 4'(i)); step();
        end
        idle(); flush = 1; dsp(XOR_OP, 1, 2, 0, 0, 0, 0, 8); step();
        chk("flush_op", opnum_to_ex, NULL_OP);
        chk("flush_full", full, 0);
        idle(); alu_valid = 1; alu_rob_id = 7; alu_data = 3; step();
        idle(); step(); step();
        chk("flush_gone", opnum_to_ex, NULL_OP);

        idle(); dsp(XOR_OP, 32'hAA, 32'hBB, 0, 0, 0, 0, 5); step();
        idle(); rdy = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rdy_hold", opnum_to_ex, NULL_OP);
        end
        rdy = 1; step();
        chk("rdy_op", opnum_to_ex, XOR_OP);
        chk("rdy_V1", V1_to_ex, 32'hAA);

        for (int c = 0; c < 600; c++) begin
            idle();
            rdy   = ($urandom_range(0, 9) != 0);
            flush = ($urandom_range(0, 39) == 0);
            if (!e_full && $urandom_range(0, 2) != 0)
                dsp(6'($urandom_range(1, 5)), $urandom, $urandom,
                    $urandom_range(0, 1), 4'($urandom_range(0, 7)),
                    $urandom_range(0, 1), 4'($urandom_range(0, 7)), 4'($urandom));
            alu_valid = $urandom_range(0, 1); alu_rob_id = 4'($urandom_range(0, 7)); alu_data = $urandom;
            lsb_valid = $urandom_range(0, 1); lsb_rob_id = 4'($urandom_range(0, 7)); lsb_data = $urandom;
            step();
        end

        idle(); dsp(ADD, 1, 1, 0, 0, 0, 0, 2); step();
        #2 rst_n = 0; #1;
        model_reset();
        chk("midreset_op", opnum_to_ex, NULL_OP);
        chk("midreset_full", full, 0);
        idle();
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
        step(); step();
        chk("post_reset_null", opnum_to_ex, NULL_OP);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
